mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Main control state machine for the multi-cycle MIPS core. It decodes OpCode/Funct from the instruction register and sequences the shared ALU, memory, register file and PC over IF/ID/EX/MEM/WB states. Per state it drives every datapath mux select and write enable, plus the 4-bit ALUOp consumed by the ALU control decoder. A retired-instruction counter is included for performance checks.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
OpCode  in  6  IR[31:26], stable from ID onward
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, same-cycle
PCWrite  out  1  PC load enable
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
IRWrite  out  1  instruction register load
MemtoReg  out  2  write data: 0 ALUOut, 1 MDR, 2 PC
RegDst  out  2  write reg: 0 rt, 1 rd, 2 $31
RegWrite  out  1  register file write
ExtOp  out  1  1 sign-extend, 0 zero-extend
LuiOp  out  1  immediate shifted left 16
ALUSrcA  out  2  0 PC, 1 A, 2 shamt
ALUSrcB  out  2  0 B, 1 constant 4, 2 ext imm, 3 ext imm<<2
ALUOp  out  4  [2:0]: 000 ADD, 001 R-type (Funct), 010 SLT, 011 SUB, 100 AND; [3]=1 unsigned I-type
PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 A
IllegalOp  out  1  one-cycle pulse on unsupported opcode/funct
State  out  4  current state, for debug
RetiredCnt  out  CNT_W  instructions completed

Behaviour:
- Moore outputs, decoded from State plus OpCode/Funct; unlisted controls are 0 and ALUOp is ADD.
- Reset low: State=S_RST(15), RetiredCnt=0, all outputs 0. S_RST drives nothing and goes to S_IF on the next edge. Reset asserted mid-instruction aborts with no further writes.
- S_IF(0): MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0. Next state is S_ID.
- S_ID(1): ALUSrcA=0, ALUSrcB=3, ExtOp=1, ADD (branch target into ALUOut). Dispatch by OpCode:
  - lw 0x23, sw 0x2b go to S_MEMADR(2).
  - R-type 0x00 goes to S_JR(12) if Funct is 0x08/0x09, to S_EXR(6) for other legal Funct, else illegal.
  - addi 08, addiu 09, slti 0a, sltiu 0b, andi 0c, lui 0f go to S_EXI(10).
  - beq 04 goes to S_BEQ(8).
  - j 02, jal 03 go to S_JMP(9).
  - Anything else pulses IllegalOp and returns to S_IF; the instruction is not retired.
- S_MEMADR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ADD. lw goes to S_MEMRD(3); sw goes to S_MEMWR(5).
- S_MEMRD: MemRead, IorD=1. Next state is S_WBLW(4).
- S_WBLW: RegWrite, MemtoReg=1, RegDst=0. Next state is S_IF.
- S_MEMWR: MemWrite, IorD=1. Next state is S_IF.
- S_EXR: ALUOp=0001. ALUSrcA=2 for Funct 00/02/03 (shifts), else 1. ALUSrcB=0. Next state is S_WBR(7).
- S_WBR: RegWrite, RegDst=1, MemtoReg=0. Next state is S_IF.
- S_EXI: ALUSrcA=1, ALUSrcB=2.
  - ALUOp: addi/addiu 0000; slti 0010; sltiu 1010; andi 0100 with ExtOp=0; lui 0000 with LuiOp=1.
  - ExtOp=1 except andi.
  - Next state is S_WBI(11).
- S_WBI: RegWrite, RegDst=0, MemtoReg=0, operand controls held as in S_EXI. Next state is S_IF.
- S_BEQ: ALUSrcA=1, ALUSrcB=0, ALUOp=0011, PCSource=1, PCWrite=Zero. Next state is S_IF.
- S_JMP: PCWrite, PCSource=2. For jal, also RegWrite, RegDst=2, MemtoReg=2 (PC already +4). Next state is S_IF.
- S_JR: PCWrite, PCSource=3. For jalr, also RegWrite, RegDst=1, MemtoReg=2. Next state is S_IF.
- Latencies in cycles: lw 5; sw, R, I-type 4; beq, j, jal, jr, jalr 3.
- RetiredCnt increments by 1 on every transition from a final state into S_IF (illegal excluded). It wraps at 2^CNT_W−1 to 0.
- Undefined State values (13, 14) go to S_IF with outputs 0.

Decomposition:
- Shared package/header holds:
  - state codes S_*;
  - ALUOp codes ALUOp_ADD/NULL/SLT/SUB/AND plus the unsigned bit;
  - opcode and funct constants;
  - mux select encodings (ALUSrcA/B, PCSource, MemtoReg, RegDst).
- One natural sub-module is mc_next_state (combinational next-state decode); output decode stays in the top.

Test Plan:
- Reset low for 3 cycles, then high → outputs 0, State=15 then 0; first IF asserts MemRead=IRWrite=PCWrite=1.
- lw (OpCode 0x23) → states 0,1,2,3,4; RegWrite=1 only in state 4 with MemtoReg=1; RetiredCnt +1.
- R-type sll (Funct 0x00) → S_EXR has ALUSrcA=2, ALUOp=0001; sltiu (0x0b) → ALUOp=1010, ExtOp=1; andi → ALUOp=0100, ExtOp=0.
- beq with Zero=1 → PCWrite=1, PCSource=1 in state 8; with Zero=0 → PCWrite=0; 3 cycles each.
- jal → state 9: PCWrite=1, PCSource=2, RegDst=2, MemtoReg=2; jalr (0x00/0x09) → state 12, PCSource=3, RegDst=1.
- OpCode 0x3f → IllegalOp pulses once in ID, returns to IF, RetiredCnt unchanged; reset low during state 3 → immediate State=15, all enables 0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// mc_control_fsm_pkg: state codes, ALUOp codes, opcode/funct constants and mux
// select encodings shared by the multi-cycle MIPS control FSM.
package mc_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_WBLW   = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXR    = 4'd6,
      S_WBR    = 4'd7,
      S_BEQ    = 4'd8,
      S_JMP    = 4'd9,
      S_EXI    = 4'd10,
      S_WBI    = 4'd11,
      S_JR     = 4'd12,
      S_RST    = 4'd15
   } state_e;

   localparam logic [2:0] ALUOp_ADD  = 3'b000;
   localparam logic [2:0] ALUOp_NULL = 3'b001;
   localparam logic [2:0] ALUOp_SLT  = 3'b010;
   localparam logic [2:0] ALUOp_SUB  = 3'b011;
   localparam logic [2:0] ALUOp_AND  = 3'b100;
   localparam logic       ALUOp_UNS  = 1'b1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_A     = 2'd1;
   localparam logic [1:0] SRCA_SHAMT = 2'd2;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_4      = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SL = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_A      = 2'd3;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   // Shift-by-immediate takes its first operand from the shamt field.
   function automatic logic is_shamt(input logic [5:0] f);
      return f inside {FN_SLL, FN_SRL, FN_SRA};
   endfunction

   function automatic logic r_legal(input logic [5:0] f);
      return f inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                       FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                       FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
   endfunction

   function automatic logic is_itype(input logic [5:0] op);
      return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI};
   endfunction

endpackage

// File: rtl/mc_control_fsm_next_state.sv
// mc_next_state: combinational next-state decode, illegal-op detect and
// retire detect for the multi-cycle control FSM.
module mc_next_state
   import mc_control_fsm_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] next_o,
   output logic       illegal_o,
   output logic       retire_o
);

   logic [3:0] id_next;

   always_comb begin
      id_next = S_IF;
      if (opcode_i == OP_LW || opcode_i == OP_SW)
         id_next = S_MEMADR;
      else if (opcode_i == OP_RTYPE)
         id_next = (funct_i == FN_JR || funct_i == FN_JALR) ? S_JR :
                   r_legal(funct_i) ? S_EXR : S_IF;
      else if (is_itype(opcode_i))
         id_next = S_EXI;
      else if (opcode_i == OP_BEQ)
         id_next = S_BEQ;
      else if (opcode_i == OP_J || opcode_i == OP_JAL)
         id_next = S_JMP;
   end

   always_comb begin
      next_o = S_IF;
      case (state_i)
         S_IF:     next_o = S_ID;
         S_ID:     next_o = id_next;
         S_MEMADR: next_o = (opcode_i == OP_LW) ? S_MEMRD :
                            (opcode_i == OP_SW) ? S_MEMWR : S_IF;
         S_MEMRD:  next_o = S_WBLW;
         S_EXR:    next_o = S_WBR;
         S_EXI:    next_o = S_WBI;
         default:  next_o = S_IF;
      endcase
   end

   // Every legal dispatch leaves ID for a state other than IF.
   assign illegal_o = (state_i == S_ID) && (id_next == S_IF);
   assign retire_o  = state_i inside {S_WBLW, S_MEMWR, S_WBR, S_WBI, S_BEQ, S_JMP, S_JR};

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main control; Moore output decode from the
// current state plus OpCode/Funct, with a retired-instruction counter.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       OpCode,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       RegDst,
   output logic             RegWrite,
   output logic             ExtOp,
   output logic             LuiOp,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [3:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             IllegalOp,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] RetiredCnt
);

   state_e           state_q, state_d;
   logic [3:0]       next;
   logic             illegal, retire;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       exi_aluop;

   mc_next_state u_next_state (
      .state_i   (state_q),
      .opcode_i  (OpCode),
      .funct_i   (Funct),
      .next_o    (next),
      .illegal_o (illegal),
      .retire_o  (retire)
   );

   assign state_d    = state_e'(next);
   assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   assign State      = state_q;
   assign RetiredCnt = cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign exi_aluop = (OpCode == OP_SLTI)  ? {1'b0, ALUOp_SLT} :
                      (OpCode == OP_SLTIU) ? {ALUOp_UNS, ALUOp_SLT} :
                      (OpCode == OP_ANDI)  ? {1'b0, ALUOp_AND} : {1'b0, ALUOp_ADD};

   always_comb begin
      PCWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      MemtoReg  = M2R_ALUOUT;
      RegDst    = DST_RT;
      RegWrite  = 1'b0;
      ExtOp     = 1'b0;
      LuiOp     = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_B;
      ALUOp     = {1'b0, ALUOp_ADD};
      PCSource  = PCSRC_ALU;
      IllegalOp = 1'b0;
      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = SRCB_4;
         end
         S_ID: begin
            ALUSrcB   = SRCB_IMM_SL;
            ExtOp     = 1'b1;
            IllegalOp = illegal;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
            ExtOp   = 1'b1;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_WBLW: begin
            RegWrite = 1'b1;
            MemtoReg = M2R_MDR;
            RegDst   = DST_RT;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXR: begin
            ALUOp   = {1'b0, ALUOp_NULL};
            ALUSrcA = is_shamt(Funct) ? SRCA_SHAMT : SRCA_A;
         end
         S_WBR: begin
            RegWrite = 1'b1;
            RegDst   = DST_RD;
         end
         // Operand controls stay valid through write-back so ALUOut is stable.
         S_EXI, S_WBI: begin
            ALUSrcA  = SRCA_A;
            ALUSrcB  = SRCB_IMM;
            ALUOp    = exi_aluop;
            ExtOp    = OpCode != OP_ANDI;
            LuiOp    = OpCode == OP_LUI;
            RegWrite = state_q == S_WBI;
         end
         S_BEQ: begin
            ALUSrcA  = SRCA_A;
            ALUOp    = {1'b0, ALUOp_SUB};
            PCSource = PCSRC_ALUOUT;
            PCWrite  = Zero;
         end
         S_JMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
            if (OpCode == OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = DST_RA;
               MemtoReg = M2R_PC;
            end
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_A;
            if (Funct == FN_JALR) begin
               RegWrite = 1'b1;
               RegDst   = DST_RD;
               MemtoReg = M2R_PC;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed instruction walk through the control FSM with
// hand-computed expected states, controls and retired counts.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  OpCode, Funct;
   logic        Zero;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp, IllegalOp;
   logic [1:0]  MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
   logic [3:0]  ALUOp, State;
   logic [31:0] RetiredCnt;
   logic [22:0] ctl;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ExtOp(ExtOp), .LuiOp(LuiOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State),
      .RetiredCnt(RetiredCnt)
   );

   assign ctl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                 ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; OpCode = 6'h00; Funct = 6'h00; Zero = 1'b0;
      repeat (3) step();
      chk("rst_state", State, 15);
      chk("rst_ctl", ctl, 0);
      chk("rst_cnt", RetiredCnt, 0);
      reset = 1'b1;
      #1 chk("rel_state", State, 15);
      step();
      chk("if_state", State, 0);
      chk("if_fetch", {MemRead, IRWrite, PCWrite, IorD, ALUSrcB}, {4'b1110, 2'd1});
      // lw
      OpCode = 6'h23;
      step(); chk("lw_id", State, 1);
      chk("lw_id_ctl", {ALUSrcA, ALUSrcB, ExtOp, RegWrite}, {2'd0, 2'd3, 2'b10});
      step(); chk("lw_adr", State, 2);
      chk("lw_adr_ctl", {ALUSrcA, ALUSrcB, ExtOp, RegWrite}, {2'd1, 2'd2, 2'b10});
      step(); chk("lw_rd", State, 3);
      chk("lw_rd_ctl", {MemRead, IorD, RegWrite}, 3'b110);
      step(); chk("lw_wb", State, 4);
      chk("lw_wb_ctl", {RegWrite, MemtoReg, RegDst}, {1'b1, 2'd1, 2'd0});
      chk("lw_cnt_pre", RetiredCnt, 0);
      step(); chk("lw_done", State, 0);
      chk("lw_cnt", RetiredCnt, 1);
      // sll
      OpCode = 6'h00; Funct = 6'h00;
      step(); chk("sll_id", State, 1);
      step(); chk("sll_ex", State, 6);
      chk("sll_ex_ctl", {ALUSrcA, ALUSrcB, ALUOp}, {2'd2, 2'd0, 4'b0001});
      step(); chk("sll_wb", State, 7);
      chk("sll_wb_ctl", {RegWrite, RegDst, MemtoReg}, {1'b1, 2'd1, 2'd0});
      step(); chk("sll_cnt", RetiredCnt, 2);
      // add uses register A, not shamt
      Funct = 6'h20;
      step(); step(); chk("add_srca", ALUSrcA, 1);
      step(); step(); chk("add_cnt", RetiredCnt, 3);
      // sltiu
      OpCode = 6'h0b;
      step(); step(); chk("sltiu_ex", State, 10);
      chk("sltiu_ctl", {ALUOp, ExtOp, ALUSrcA, ALUSrcB}, {4'b1010, 1'b1, 2'd1, 2'd2});
      step(); chk("sltiu_wb", {State, RegWrite, ALUOp}, {4'd11, 1'b1, 4'b1010});
      step(); chk("sltiu_cnt", RetiredCnt, 4);
      // andi
      OpCode = 6'h0c;
      step(); step(); chk("andi_ctl", {ALUOp, ExtOp, LuiOp}, {4'b0100, 2'b00});
      step(); step(); chk("andi_cnt", RetiredCnt, 5);
      // lui
      OpCode = 6'h0f;
      step(); step(); chk("lui_ctl", {ALUOp, ExtOp, LuiOp}, {4'b0000, 2'b11});
      step(); step(); chk("lui_cnt", RetiredCnt, 6);
      // beq taken
      OpCode = 6'h04; Zero = 1'b1;
      step(); step(); chk("beq_t_state", State, 8);
      chk("beq_t_ctl", {PCWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB}, {1'b1, 2'd1, 4'b0011, 2'd1, 2'd0});
      step(); chk("beq_t_done", {State, RetiredCnt[3:0]}, {4'd0, 4'd7});
      // beq not taken
      Zero = 1'b0;
      step(); step(); chk("beq_n_ctl", {State, PCWrite, PCSource}, {4'd8, 1'b0, 2'd1});
      step(); chk("beq_n_done", {State, RetiredCnt[3:0]}, {4'd0, 4'd8});
      // jal
      OpCode = 6'h03;
      step(); step(); chk("jal_state", State, 9);
      chk("jal_ctl", {PCWrite, PCSource, RegWrite, RegDst, MemtoReg}, {1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
      step(); chk("jal_cnt", RetiredCnt, 9);
      // j has no link write
      OpCode = 6'h02;
      step(); step(); chk("j_ctl", {State, PCWrite, RegWrite}, {4'd9, 2'b10});
      step(); chk("j_cnt", RetiredCnt, 10);
      // jalr
      OpCode = 6'h00; Funct = 6'h09;
      step(); step(); chk("jalr_state", State, 12);
      chk("jalr_ctl", {PCWrite, PCSource, RegWrite, RegDst, MemtoReg}, {1'b1, 2'd3, 1'b1, 2'd1, 2'd2});
      step(); chk("jalr_cnt", RetiredCnt, 11);
      // illegal opcode
      OpCode = 6'h3f;
      step(); chk("ill_id", {State, IllegalOp}, {4'd1, 1'b1});
      step(); chk("ill_back", {State, IllegalOp}, {4'd0, 1'b0});
      chk("ill_cnt", RetiredCnt, 11);
      // illegal R-type funct
      OpCode = 6'h00; Funct = 6'h3f;
      step(); chk("illr_id", IllegalOp, 1);
      step(); chk("illr_back", {State, RetiredCnt[3:0]}, {4'd0, 4'd11});
      // sw
      OpCode = 6'h2b; Funct = 6'h00;
      step(); step(); chk("sw_adr", State, 2);
      step(); chk("sw_wr", {State, MemWrite, IorD, RegWrite}, {4'd5, 3'b110});
      step(); chk("sw_cnt", RetiredCnt, 12);
      // reset during S_MEMRD
      OpCode = 6'h23;
      step(); step(); step(); chk("abort_pre", State, 3);
      #2 reset = 1'b0;
      #1 chk("abort_state", State, 15);
      chk("abort_ctl", ctl, 0);
      chk("abort_cnt", RetiredCnt, 0);
      step(); chk("abort_hold", State, 15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
